// File: rtl/uart_alu_frame_ctrl.sv
// -----------------------------------------------------------------------------
// uart_alu_frame_ctrl
//
// Collects a request frame from a UART receiver: operand A (NBYTES bytes),
// operand B (NBYTES bytes), then one opcode byte. Bytes arrive little-endian.
// The operands and opcode drive an external combinational ALU. One cycle after
// the opcode the ALU result is captured and sent back, least significant byte
// first, using a tx_start / tx_done handshake with the UART transmitter.
//
// A partial frame that stalls for TIMEOUT_CYC idle cycles is discarded and
// o_frame_err pulses. TIMEOUT_CYC = 0 turns the timeout off. Receive bytes
// that arrive while a result is pending or being sent are ignored, and
// o_rx_drop pulses.
//
// Ports
//   i_clk           clock; all logic runs on the rising edge
//   i_reset         synchronous reset, active low
//   i_rx_done_tick  one-cycle strobe: i_rx_data is valid
//   i_rx_data       received byte
//   i_alu_result    combinational ALU result for o_data_a/o_data_b/o_operation
//   i_tx_done_tick  one-cycle strobe: the transmitter finished the current byte
//   o_tx_start      one-cycle strobe: start transmitting o_tx_data
//   o_tx_data       byte to transmit; held stable until the next o_tx_start
//   o_data_a        operand A register
//   o_data_b        operand B register
//   o_operation     opcode register
//   o_busy          high from frame completion until the last reply byte is done
//   o_frame_err     one-cycle pulse: a partial frame was dropped on timeout
//   o_rx_drop       one-cycle pulse: an rx byte was ignored because busy
// -----------------------------------------------------------------------------
module uart_alu_frame_ctrl #(
  parameter int NB_BYTE     = 8,
  parameter int NB_DATA     = 16,
  parameter int NB_OP       = 6,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_rx_done_tick,
  input  logic [NB_BYTE-1:0] i_rx_data,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_tx_done_tick,
  output logic               o_tx_start,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic [NB_DATA-1:0] o_data_a,
  output logic [NB_DATA-1:0] o_data_b,
  output logic [NB_OP-1:0]   o_operation,
  output logic               o_busy,
  output logic               o_frame_err,
  output logic               o_rx_drop
);

  localparam int NBYTES = NB_DATA / NB_BYTE;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int CNT_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam bit TO_EN  = (TIMEOUT_CYC > 0);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  typedef enum logic [2:0] {
    RX_A    = 3'd0,
    RX_B    = 3'd1,
    RX_OP   = 3'd2,
    CAPTURE = 3'd3,
    WAIT_TX = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NB_DATA-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]   rem_q, rem_d;
  logic               tx_start_q, tx_start_d;
  logic [NB_BYTE-1:0] tx_data_q, tx_data_d;
  logic [NB_DATA-1:0] data_a_q, data_a_d;
  logic [NB_DATA-1:0] data_b_q, data_b_d;
  logic [NB_OP-1:0]   op_q, op_d;
  logic               busy_q, busy_d;
  logic               frame_err_q, frame_err_d;
  logic               rx_drop_q, rx_drop_d;

  logic frame_partial;
  logic last_byte;
  logic timeout_hit;

  // A frame is partial once its first byte is in and until the opcode lands.
  assign frame_partial = ((state_q == RX_A) && (idx_q != '0)) ||
                         (state_q == RX_B) || (state_q == RX_OP);
  assign last_byte     = (idx_q == LAST_IDX);

  // A tick in the expiry cycle takes priority, so the byte is never lost.
  generate
    if (TO_EN) begin : g_timeout
      assign timeout_hit = frame_partial && !i_rx_done_tick &&
                           (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    end else begin : g_no_timeout
      assign timeout_hit = 1'b0;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // State register (and all datapath flops)
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q     <= RX_A;
      idx_q       <= '0;
      cnt_q       <= '0;
      shift_q     <= '0;
      rem_q       <= '0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
      data_a_q    <= '0;
      data_b_q    <= '0;
      op_q        <= '0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      rx_drop_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      rem_q       <= rem_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      data_a_q    <= data_a_d;
      data_b_q    <= data_b_d;
      op_q        <= op_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
      rx_drop_q   <= rx_drop_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RX_A: begin
        if (i_rx_done_tick && last_byte) state_d = RX_B;
        else if (timeout_hit)            state_d = RX_A;
      end
      RX_B: begin
        if (i_rx_done_tick && last_byte) state_d = RX_OP;
        else if (timeout_hit)            state_d = RX_A;
      end
      RX_OP: begin
        if (i_rx_done_tick)   state_d = CAPTURE;
        else if (timeout_hit) state_d = RX_A;
      end
      CAPTURE: state_d = WAIT_TX;
      WAIT_TX: begin
        if (i_tx_done_tick && (rem_q == '0)) state_d = RX_A;
      end
      default: state_d = RX_A;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    idx_d       = idx_q;
    shift_d     = shift_q;
    rem_d       = rem_q;
    tx_start_d  = 1'b0;
    tx_data_d   = tx_data_q;
    data_a_d    = data_a_q;
    data_b_d    = data_b_q;
    op_d        = op_q;
    busy_d      = busy_q;
    frame_err_d = timeout_hit;
    rx_drop_d   = 1'b0;

    // Idle-gap counter: counts only while a frame is partial and nothing
    // arrives; any accepted byte or expiry restarts it from zero.
    if (TO_EN && frame_partial && !i_rx_done_tick && !timeout_hit)
      cnt_d = cnt_q + CNT_W'(1);
    else
      cnt_d = '0;

    unique case (state_q)
      RX_A: begin
        if (i_rx_done_tick) begin
          for (int b = 0; b < NBYTES; b++) begin
            if (idx_q == IDX_W'(b)) data_a_d[b*NB_BYTE +: NB_BYTE] = i_rx_data;
          end
          idx_d = last_byte ? '0 : idx_q + IDX_W'(1);
        end else if (timeout_hit) begin
          idx_d = '0;
        end
      end
      RX_B: begin
        if (i_rx_done_tick) begin
          for (int b = 0; b < NBYTES; b++) begin
            if (idx_q == IDX_W'(b)) data_b_d[b*NB_BYTE +: NB_BYTE] = i_rx_data;
          end
          idx_d = last_byte ? '0 : idx_q + IDX_W'(1);
        end else if (timeout_hit) begin
          idx_d = '0;
        end
      end
      RX_OP: begin
        if (i_rx_done_tick) begin
          op_d   = i_rx_data[NB_OP-1:0];
          busy_d = 1'b1;
        end else if (timeout_hit) begin
          idx_d = '0;
        end
      end
      CAPTURE: begin
        // The ALU has had one full cycle on the new operands here.
        tx_data_d  = i_alu_result[NB_BYTE-1:0];
        shift_d    = i_alu_result >> NB_BYTE;
        rem_d      = IDX_W'(NBYTES - 1);
        tx_start_d = 1'b1;
        rx_drop_d  = i_rx_done_tick;
      end
      WAIT_TX: begin
        rx_drop_d = i_rx_done_tick;
        if (i_tx_done_tick) begin
          if (rem_q != '0) begin
            tx_data_d  = shift_q[NB_BYTE-1:0];
            shift_d    = shift_q >> NB_BYTE;
            rem_d      = rem_q - IDX_W'(1);
            tx_start_d = 1'b1;
          end else begin
            busy_d = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

  assign o_tx_start  = tx_start_q;
  assign o_tx_data   = tx_data_q;
  assign o_data_a    = data_a_q;
  assign o_data_b    = data_b_q;
  assign o_operation = op_q;
  assign o_busy      = busy_q;
  assign o_frame_err = frame_err_q;
  assign o_rx_drop   = rx_drop_q;

endmodule

// File: tb/tb_uart_alu_frame_ctrl.sv
// -----------------------------------------------------------------------------
// Directed bench for uart_alu_frame_ctrl.
// dut16: 16-bit operands, 50-cycle timeout. dut8: 8-bit operands, no timeout.
// The ALU in both cases is A + B. Inputs change 1 time unit after the rising
// edge and outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_uart_alu_frame_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 16-bit instance
  logic        rx_tick16 = 1'b0;
  logic [7:0]  rx_data16 = '0;
  logic        tx_done16 = 1'b0;
  logic [15:0] alu16;
  logic        tx_start16;
  logic [7:0]  tx_data16;
  logic [15:0] a16, b16;
  logic [5:0]  op16;
  logic        busy16, ferr16, drop16;

  assign alu16 = a16 + b16;

  uart_alu_frame_ctrl #(
    .NB_BYTE(8), .NB_DATA(16), .NB_OP(6), .TIMEOUT_CYC(50)
  ) dut16 (
    .i_clk(clk), .i_reset(rst_n),
    .i_rx_done_tick(rx_tick16), .i_rx_data(rx_data16),
    .i_alu_result(alu16), .i_tx_done_tick(tx_done16),
    .o_tx_start(tx_start16), .o_tx_data(tx_data16),
    .o_data_a(a16), .o_data_b(b16), .o_operation(op16),
    .o_busy(busy16), .o_frame_err(ferr16), .o_rx_drop(drop16)
  );

  // 8-bit instance
  logic       rx_tick8 = 1'b0;
  logic [7:0] rx_data8 = '0;
  logic       tx_done8 = 1'b0;
  logic [7:0] alu8;
  logic       tx_start8;
  logic [7:0] tx_data8;
  logic [7:0] a8, b8;
  logic [5:0] op8;
  logic       busy8, ferr8, drop8;

  assign alu8 = a8 + b8;

  uart_alu_frame_ctrl #(
    .NB_BYTE(8), .NB_DATA(8), .NB_OP(6), .TIMEOUT_CYC(0)
  ) dut8 (
    .i_clk(clk), .i_reset(rst_n),
    .i_rx_done_tick(rx_tick8), .i_rx_data(rx_data8),
    .i_alu_result(alu8), .i_tx_done_tick(tx_done8),
    .o_tx_start(tx_start8), .o_tx_data(tx_data8),
    .o_data_a(a8), .o_data_b(b8), .o_operation(op8),
    .o_busy(busy8), .o_frame_err(ferr8), .o_rx_drop(drop8)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
    $display("  check %-22s observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send16(input logic [7:0] b);
    rx_data16 = b;
    rx_tick16 = 1'b1;
    step();
    rx_tick16 = 1'b0;
  endtask

  task automatic send8(input logic [7:0] b);
    rx_data8 = b;
    rx_tick8 = 1'b1;
    step();
    rx_tick8 = 1'b0;
  endtask

  task automatic pulse_done16();
    tx_done16 = 1'b1;
    step();
    tx_done16 = 1'b0;
  endtask

  // Called in the cycle right after the opcode tick (CAPTURE).
  task automatic expect_reply16(input string tag, input logic [7:0] b0, input logic [7:0] b1);
    check({tag, ".busy"}, 32'(busy16), 32'd1);
    check({tag, ".start_lat"}, 32'(tx_start16), 32'd0);
    step();
    check({tag, ".start0"}, 32'(tx_start16), 32'd1);
    check({tag, ".byte0"}, 32'(tx_data16), 32'(b0));
    step();
    check({tag, ".start0_end"}, 32'(tx_start16), 32'd0);
    pulse_done16();
    check({tag, ".start1"}, 32'(tx_start16), 32'd1);
    check({tag, ".byte1"}, 32'(tx_data16), 32'(b1));
    check({tag, ".busy_mid"}, 32'(busy16), 32'd1);
    step();
    pulse_done16();
    check({tag, ".busy_end"}, 32'(busy16), 32'd0);
    check({tag, ".no_start"}, 32'(tx_start16), 32'd0);
  endtask

  initial begin
    // Reset
    step(2);
    check("rst.a", 32'(a16), 32'd0);
    check("rst.tx_data", 32'(tx_data16), 32'd0);
    check("rst.busy", 32'(busy16), 32'd0);
    check("rst.start", 32'(tx_start16), 32'd0);
    check("rst8.op", 32'(op8), 32'd0);
    rst_n = 1'b1;
    step();

    // Basic frame: 0x1234 + 0x0011 = 0x1245
    send16(8'h34); send16(8'h12); send16(8'h11); send16(8'h00); send16(8'h20);
    check("f1.a", 32'(a16), 32'h1234);
    check("f1.b", 32'(b16), 32'h0011);
    check("f1.op", 32'(op16), 32'h20);
    expect_reply16("f1", 8'h45, 8'h12);

    // tx_done outside WAIT_TX is ignored
    pulse_done16();
    check("stray_done.start", 32'(tx_start16), 32'd0);
    check("stray_done.busy", 32'(busy16), 32'd0);

    // Timeout after a partial frame: error pulse in the 51st cycle
    send16(8'h34); send16(8'h12); send16(8'h11);
    step(49);
    check("to.early", 32'(ferr16), 32'd0);
    step();
    check("to.pulse", 32'(ferr16), 32'd1);
    step();
    check("to.pulse_end", 32'(ferr16), 32'd0);
    send16(8'h01); send16(8'h00); send16(8'h02); send16(8'h00); send16(8'h20);
    check("to.a", 32'(a16), 32'h0001);
    check("to.b", 32'(b16), 32'h0002);
    expect_reply16("to_f", 8'h03, 8'h00);
    check("to_f.no_err", 32'(ferr16), 32'd0);

    // Tick in the expiry cycle wins
    send16(8'h01);
    step(49);
    send16(8'h02);
    check("tw.no_err", 32'(ferr16), 32'd0);
    check("tw.a", 32'(a16), 32'h0201);
    step();
    check("tw.no_err2", 32'(ferr16), 32'd0);
    send16(8'h10); send16(8'h00); send16(8'h20);
    check("tw.b", 32'(b16), 32'h0010);

    // Busy drop during WAIT_TX; reply 0x0211
    check("dr.busy", 32'(busy16), 32'd1);
    step();
    check("dr.start0", 32'(tx_start16), 32'd1);
    check("dr.byte0", 32'(tx_data16), 32'h11);
    send16(8'hAA);
    check("dr.drop", 32'(drop16), 32'd1);
    check("dr.a_kept", 32'(a16), 32'h0201);
    check("dr.b_kept", 32'(b16), 32'h0010);
    step();
    check("dr.drop_end", 32'(drop16), 32'd0);
    pulse_done16();
    check("dr.start1", 32'(tx_start16), 32'd1);
    check("dr.byte1", 32'(tx_data16), 32'h02);
    step();
    pulse_done16();
    check("dr.busy_end", 32'(busy16), 32'd0);

    // Reset after the 4th byte
    send16(8'hAB); send16(8'hCD); send16(8'h01); send16(8'h00);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("r1.a", 32'(a16), 32'd0);
    check("r1.b", 32'(b16), 32'd0);
    check("r1.op", 32'(op16), 32'd0);
    send16(8'h05); send16(8'h00); send16(8'h07); send16(8'h00); send16(8'h01);
    check("r1f.op", 32'(op16), 32'h01);
    check("r1f.busy", 32'(busy16), 32'd1);
    step();
    check("r1f.start0", 32'(tx_start16), 32'd1);
    check("r1f.byte0", 32'(tx_data16), 32'h0C);

    // Reset during WAIT_TX
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("r2.busy", 32'(busy16), 32'd0);
    check("r2.tx_data", 32'(tx_data16), 32'd0);
    check("r2.start", 32'(tx_start16), 32'd0);
    check("r2.a", 32'(a16), 32'd0);
    send16(8'hFF); send16(8'h00); send16(8'h01); send16(8'h00); send16(8'h3F);
    check("r2f.op", 32'(op16), 32'h3F);
    expect_reply16("r2f", 8'h00, 8'h01);

    // 8-bit instance: 0x05 + 0x03, opcode 0xE0 truncated to 0x20
    send8(8'h05); send8(8'h03); send8(8'hE0);
    check("n8.a", 32'(a8), 32'h05);
    check("n8.b", 32'(b8), 32'h03);
    check("n8.op", 32'(op8), 32'h20);
    check("n8.busy", 32'(busy8), 32'd1);
    step();
    check("n8.start", 32'(tx_start8), 32'd1);
    check("n8.byte0", 32'(tx_data8), 32'h08);
    step();
    tx_done8 = 1'b1;
    step();
    tx_done8 = 1'b0;
    check("n8.busy_end", 32'(busy8), 32'd0);
    check("n8.no_start", 32'(tx_start8), 32'd0);
    check("n8.no_err", 32'(ferr8), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_alu_frame_ctrl.md
Name: uart_alu_frame_ctrl

Overview:
Parametrised successor to the UART-to-ALU interface. Assembles a frame of multi-byte operand A, multi-byte operand B and an opcode byte from the UART receiver, and drives the external combinational ALU. It then serialises the multi-byte ALU result back to the UART transmitter with a full tx_start/tx_done handshake. Adds an inter-byte timeout with frame discard, and drop signalling for bytes that arrive while busy.

Parameters:
NB_BYTE, 8, UART character width
NB_DATA, 16, operand/result width; must be a multiple of NB_BYTE; NBYTES = NB_DATA/NB_BYTE (≥1)
NB_OP, 6, opcode width; taken from the low NB_OP bits of the opcode byte
TIMEOUT_CYC, 100000, idle clock cycles allowed between bytes of one frame; 0 disables the timeout

Ports:
i_clk  in  1  clock, all logic on rising edge
i_reset  in  1  synchronous, active-low reset
i_rx_done_tick  in  1  one-cycle strobe: i_rx_data valid
i_rx_data  in  NB_BYTE  received byte
i_alu_result  in  NB_DATA  combinational ALU result for o_data_a/o_data_b/o_operation
i_tx_done_tick  in  1  one-cycle strobe: transmitter finished the current byte
o_tx_start  out  1  one-cycle strobe: start transmitting o_tx_data
o_tx_data  out  NB_BYTE  byte to transmit; held stable until the next o_tx_start
o_data_a  out  NB_DATA  operand A register
o_data_b  out  NB_DATA  operand B register
o_operation  out  NB_OP  opcode register
o_busy  out  1  high from frame completion until the last result byte's tx_done
o_frame_err  out  1  one-cycle pulse: partial frame discarded by timeout
o_rx_drop  out  1  one-cycle pulse: rx byte ignored because the block is busy

Behaviour:
- Reset (i_reset=0 at a clock edge): every output 0, state RX_A, byte index 0, timeout counter 0, tx shift register 0. Reset wins over all other events, including mid-frame and mid-transmission; a partial frame or partial result is lost.
- FSM states: RX_A, RX_B, RX_OP, CAPTURE, WAIT_TX.
- Byte order is little-endian: the first byte received or sent is bits [NB_BYTE-1:0].
- RX_A: each tick writes i_rx_data into byte slot idx of o_data_a, then idx++. On the NBYTES-th byte, idx goes to 0 and the state goes to RX_B.
- RX_B: same as RX_A, writing into o_data_b; then to RX_OP.
- RX_OP: a tick loads o_operation with i_rx_data[NB_OP-1:0] and moves to CAPTURE. o_busy goes to 1 in the same edge.
- CAPTURE (exactly 1 cycle, lets the ALU settle):
  - o_tx_data <= i_alu_result[NB_BYTE-1:0]
  - shift register <= i_alu_result >> NB_BYTE
  - remaining <= NBYTES-1
  - o_tx_start <= 1
  - state <= WAIT_TX
- Latency: opcode tick in cycle n → o_operation updated at n+1 → o_tx_start high in cycle n+2.
- WAIT_TX: o_tx_start is 0 except as pulsed below. On i_tx_done_tick:
  - If remaining>0: o_tx_data <= shift[NB_BYTE-1:0], shift >>= NB_BYTE, remaining--, o_tx_start pulses the next cycle.
  - Else: o_busy <= 0 and state <= RX_A.
- Operand and opcode registers hold their values until overwritten by the next frame; they are not cleared at frame end.
- Busy drop: an rx tick in CAPTURE or WAIT_TX is ignored. o_rx_drop pulses the next cycle and frame registers are unchanged.
- Timeout (TIMEOUT_CYC>0):
  - The counter runs only while a frame is partial, i.e. state RX_A with idx≠0, or RX_B, or RX_OP.
  - It clears on every accepted rx tick and is held at 0 otherwise.
  - When it reaches TIMEOUT_CYC-1 with no tick that cycle: state <= RX_A, idx <= 0, counter <= 0, o_frame_err pulses 1 cycle. Already-written register bytes are kept and are overwritten by the next frame.
  - If a tick arrives in the same cycle the counter hits TIMEOUT_CYC-1, the tick wins: the byte is accepted and there is no error.
- i_tx_done_tick outside WAIT_TX is ignored.
- NBYTES=1 degenerates to the 3-byte A/B/op protocol with a 1-byte reply.

Test Plan:
- NB_DATA=16, bench ALU = A+B. Send 0x34,0x12,0x11,0x00,0x20 → o_data_a=0x1234, o_data_b=0x0011, o_operation=0x20, o_busy=1. o_tx_start 2 cycles after the opcode tick with o_tx_data=0x45; after tx_done, second start with 0x12; after the second tx_done, o_busy=0.
- Send 0x34,0x12,0x11, then idle TIMEOUT_CYC cycles (set to 50) → o_frame_err pulses once; next 5 bytes 0x01,0,0x02,0,0x20 → reply 0x03,0x00, no error.
- Tick at exactly cycle TIMEOUT_CYC-1 of idle → byte accepted, no o_frame_err.
- Send an rx byte 0xAA while WAIT_TX → o_rx_drop pulses, o_data_a unchanged, reply bytes unaffected.
- Assert i_reset=0 after the 4th byte and again during WAIT_TX → all outputs 0, state RX_A; a following full frame completes normally.
- Re-parametrise NB_DATA=8, NB_OP=6: send 0x05,0x03,0xE0 → o_operation=0x20, single reply byte 0x08.
